cmp_branch_pred: RTL
====================

# cmp_branch_pred

Parametrised branch-resolution unit for the D stage of the pipelined MIPS32 core. It extends the single-purpose beq equality comparator to six compare operations, with a selectable datapath width. It waits in a hazard state while forwarded operands are still pending, and keeps a per-PC table of 2-bit saturating counters so it can report predicted direction and mispredict alongside each resolved outcome.

## Interface
- WIDTH, 32, operand width in bits (signed compares use bit WIDTH-1)
- PC_WIDTH, 32, width of req_pc
- IDX_BITS, 4, log2 of predictor entries; index = req_pc[IDX_BITS+1:2]

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req_valid  in  1  branch present in D stage
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  3  000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez, 110/111 illegal
- req_pc  in  PC_WIDTH  branch instruction address
- cmp_in1  in  WIDTH  rs operand (live forwarded value)
- cmp_in2  in  WIDTH  rt operand (used by beq/bne only)
- in1_avail  in  1  cmp_in1 is final (no pending producer)
- in2_avail  in  1  cmp_in2 is final; ignored for ops 010-111
- flush  in  1  abort any accepted, unresolved request
- pred_taken  out  1  combinational prediction for req_pc (counter MSB)
- stall  out  1  high while in WAIT
- res_valid  out  1  one-cycle pulse: outcome registered
- res_taken  out  1  resolved direction, valid with res_valid
- res_mispredict  out  1  res_taken != prediction latched at accept

## Operation
- States: IDLE, WAIT. req_ready = (state == IDLE); stall = (state == WAIT).
- IDLE, req_valid=1, flush=0: latch op, pc index, pred_taken. If required operands are available this cycle, evaluate now and stay IDLE; otherwise go to WAIT.
- WAIT: re-read cmp_in1/cmp_in2 every cycle (upstream holds the instruction, forwarding updates values). Evaluate in the first cycle all required avail are 1, then go to IDLE.
- Evaluate: beq in1==in2; bne in1!=in2; blez signed in1<=0; bgtz signed in1>0; bltz in1[WIDTH-1]; bgez !in1[WIDTH-1]; illegal ops resolve not taken.
- At the edge closing an evaluate cycle:
  - res_valid<=1, res_taken<=cond, res_mispredict<=cond^latched_pred.
  - The indexed counter updates: taken increments and saturates at 11; not taken decrements and saturates at 00.
- res_valid and res_mispredict are 0 in every other cycle; res_taken holds its last value.
- flush=1 in IDLE or WAIT: return/stay in IDLE, no result, no counter update; flush has priority over req_valid and over avail in the same cycle.
- Reset values: state IDLE, res_valid 0, res_taken 0, res_mispredict 0, stall 0, all counters 01 (weakly not taken), so pred_taken reads 0.

## Timing
- Latency: with operands ready at accept, res_valid asserts in the next cycle. With N wait cycles, res_valid asserts N+1 cycles after accept.
- Throughput: one branch per cycle when operands are ready (back-to-back accepts in IDLE).
- Predictor read is combinational from the table state at the start of the cycle. An update from the previous resolve is already visible; there is no same-cycle bypass.
- Two branches aliasing to the same index share one counter, with no tag check.
- An async reset mid-WAIT drops the pending request; outputs go to reset values without waiting for a clock edge.
- req_valid in WAIT is ignored; the upstream stage must hold it stable while stall=1.

## Test plan
- After reset, beq pc=0x3000 in1=in2=5 with both avail -> pred_taken=0. Next cycle: res_valid=1, res_taken=1, res_mispredict=1. Counter[0] moves 01->10.
- Repeat the same beq -> pred_taken=1, res_mispredict=0, counter 11. A third not-taken beq (in2=6) -> res_mispredict=1, counter 10.
- Signed edges, WIDTH=32:
  - bltz in1=0x8000_0000 -> taken.
  - bgtz in1=0 -> not taken.
  - blez in1=0 -> taken.
  - bgez in1=0x7FFF_FFFF -> taken.
  - op=111 -> not taken.
- Hazard: accept bne with in1_avail=0 for 3 cycles -> stall=1 for 3 cycles and req_ready=0. in1 changes 7->9 with in2=9 as avail rises -> res_valid one cycle later, res_taken=0.
- flush in the second WAIT cycle -> stall drops next cycle, no res_valid ever, counter unchanged; the following request is accepted normally.
- Assert reset (low) during WAIT -> stall/res_valid go 0 immediately and all counters return to 01. After release, pred_taken=0 for the previously trained pc.

Source files
------------

// File: rtl/cmp_branch_pred.sv
// Branch-resolution unit for the D stage.
// Evaluates six compare ops and waits in WAIT while forwarded operands are
// still pending. A table of 2-bit saturating counters, indexed by the low
// word-address bits of the PC, supplies the predicted direction. Each resolved
// outcome is flagged as a mispredict when it differs from that prediction.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a branch; resolves at once when operands are final
// WAIT  | branch accepted, holding until the required operands are final
module cmp_branch_pred #(
    parameter int WIDTH    = 32,
    parameter int PC_WIDTH = 32,
    parameter int IDX_BITS = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [2:0]          req_op_i,
    input  logic [PC_WIDTH-1:0] req_pc_i,
    input  logic [WIDTH-1:0]    cmp_in1_i,
    input  logic [WIDTH-1:0]    cmp_in2_i,
    input  logic                in1_avail_i,
    input  logic                in2_avail_i,
    input  logic                flush_i,
    output logic                pred_taken_o,
    output logic                stall_o,
    output logic                res_valid_o,
    output logic                res_taken_o,
    output logic                res_mispredict_o
);

    localparam int ENTRIES = 1 << IDX_BITS;

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLEZ = 3'b010;
    localparam logic [2:0] OP_BGTZ = 3'b011;
    localparam logic [2:0] OP_BLTZ = 3'b100;
    localparam logic [2:0] OP_BGEZ = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                state_q;
    logic [2:0]            op_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic                  pred_q;
    logic                  res_valid_q;
    logic                  res_taken_q;
    logic                  res_mispredict_q;
    logic [1:0]            cnt_q [ENTRIES];

    logic                  in_idle;
    logic [2:0]            eval_op;
    logic [IDX_BITS-1:0]   req_idx;
    logic [IDX_BITS-1:0]   eval_idx;
    logic                  eval_pred;
    logic                  need_in2;
    logic                  ops_ready;
    logic                  fire;
    logic                  cond;
    logic                  in1_neg;
    logic                  in1_zero;
    logic [1:0]            cnt_d;

    // Only the word-address bits that form the index are used for the lookup.
    logic unused_pc;
    assign unused_pc = ^{req_pc_i[PC_WIDTH-1:IDX_BITS+2], req_pc_i[1:0]};

    // Select the branch being resolved this cycle: the live request in IDLE,
    // the latched one in WAIT. Operand values are always taken live.
    always_comb begin
        in_idle   = (state_q == S_IDLE);
        req_idx   = req_pc_i[IDX_BITS+1:2];
        eval_op   = in_idle ? req_op_i : op_q;
        eval_idx  = in_idle ? req_idx  : idx_q;
        eval_pred = in_idle ? pred_taken_o : pred_q;
        need_in2  = (eval_op == OP_BEQ) || (eval_op == OP_BNE);
        ops_ready = in1_avail_i && (!need_in2 || in2_avail_i);
        fire      = !flush_i && (in_idle ? req_valid_i : 1'b1) && ops_ready;
    end

    // Branch condition; sign comes from the operand MSB.
    always_comb begin
        in1_neg  = cmp_in1_i[WIDTH-1];
        in1_zero = (cmp_in1_i == '0);
        cond     = 1'b0;
        case (eval_op)
            OP_BEQ:  cond = (cmp_in1_i == cmp_in2_i);
            OP_BNE:  cond = (cmp_in1_i != cmp_in2_i);
            OP_BLEZ: cond = in1_neg || in1_zero;
            OP_BGTZ: cond = !in1_neg && !in1_zero;
            OP_BLTZ: cond = in1_neg;
            OP_BGEZ: cond = !in1_neg;
            default: cond = 1'b0;
        endcase
    end

    // Saturating next value for the counter being trained.
    always_comb begin
        cnt_d = cnt_q[eval_idx];
        if (cond) begin
            if (cnt_q[eval_idx] != 2'b11) cnt_d = cnt_q[eval_idx] + 2'd1;
        end else begin
            if (cnt_q[eval_idx] != 2'b00) cnt_d = cnt_q[eval_idx] - 2'd1;
        end
    end

    // Sequencing FSM with registered result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= S_IDLE;
            op_q             <= 3'b000;
            idx_q            <= '0;
            pred_q           <= 1'b0;
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
        end else begin
            res_valid_q      <= fire;
            res_mispredict_q <= fire && (cond ^ eval_pred);
            if (fire) res_taken_q <= cond;
            if (flush_i) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req_valid_i) begin
                            op_q   <= req_op_i;
                            idx_q  <= req_idx;
                            pred_q <= pred_taken_o;
                            if (!ops_ready) state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (ops_ready) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Predictor table: trained only by a branch that actually resolves.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
        end else if (fire) begin
            cnt_q[eval_idx] <= cnt_d;
        end
    end

    assign pred_taken_o     = cnt_q[req_pc_i[IDX_BITS+1:2]][1];
    assign req_ready_o      = (state_q == S_IDLE);
    assign stall_o          = (state_q == S_WAIT);
    assign res_valid_o      = res_valid_q;
    assign res_taken_o      = res_taken_q;
    assign res_mispredict_o = res_mispredict_q;

endmodule
